axis_round_robin_merge: RTL and testbench
=========================================

Name: axis_round_robin_merge

Overview:
- Reassembles N parallel AXI-Stream lanes into one output stream, taking from each lane in strict rotating order: 0, 1, …, N-1, 0, …
- It is the downstream counterpart of axis_round_robin. Lanes fanned out to parallel workers are recombined here in the original order, even when the workers have unequal latency.
- It never skips an idle lane. It waits on the lane whose turn it is.
- The output is registered: one pipeline stage, full throughput.

Parameters:
- AXIS_BYTES, 1, data width in bytes. tdata width is AXIS_BYTES*8.
- NUM_MASTER_STREAMS, 2, number of input lanes. Must be ≥ 2.
- PACKET_MODE, 1:
  - 1 = the pointer advances after a beat with tlast=1.
  - 0 = the pointer advances after every beat.

Ports:
- clk  in  1  clock.
- sresetn  in  1  synchronous reset, active-low.
- axis_i_tready  out  NUM_MASTER_STREAMS  per-lane ready. Bit k belongs to lane k.
- axis_i_tvalid  in  NUM_MASTER_STREAMS  per-lane valid.
- axis_i_tdata  in  NUM_MASTER_STREAMS*AXIS_BYTES*8  lane k occupies bits [(k+1)*AXIS_BYTES*8-1 : k*AXIS_BYTES*8].
- axis_i_tlast  in  NUM_MASTER_STREAMS  per-lane last.
- axis_o_tready  in  1  downstream ready.
- axis_o_tvalid  out  1  output valid (registered).
- axis_o_tdata  out  AXIS_BYTES*8  output data (registered).
- axis_o_tlast  out  1  output last (registered).

Behaviour:
- State:
  - sel: lane pointer, width $clog2(NUM_MASTER_STREAMS), minimum 1 bit.
  - Output register {valid, data, last}.
- Reset (sresetn=0 at a rising edge):
  - sel=0, axis_o_tvalid=0.
  - axis_o_tdata and axis_o_tlast=0.
  - axis_i_tready is all 0 while sresetn=0.
  - Reset applies mid-packet with no flush. Partially transferred packets are abandoned, and after reset the block expects a packet start on lane 0.
- Output register ready:
  - out_free = !axis_o_tvalid | axis_o_tready (combinational).
- Input readiness:
  - axis_i_tready[k] = sresetn & out_free & (k==sel).
  - Every non-selected lane sees tready=0 regardless of its tvalid.
- Accepted beat:
  - accept = axis_i_tvalid[sel] & axis_i_tready[sel].
  - On accept, the output register loads data[sel], last[sel] and valid=1, all on the next edge.
- Output drain:
  - If out_free and no accept, axis_o_tvalid goes to 0 on the next edge.
  - If the output is held (axis_o_tvalid=1, axis_o_tready=0), data, last and valid are stable, as AXI-Stream requires.
- Latency and throughput:
  - Input beat to axis_o_tvalid is 1 cycle.
  - Sustained throughput is 1 beat/cycle, including back-to-back across lane switches (no bubble on a pointer advance).
- Pointer advance:
  - Happens on accept when (PACKET_MODE==0) or axis_i_tlast[sel]==1.
  - Update is sel <= (sel==NUM_MASTER_STREAMS-1) ? 0 : sel+1. Explicit wrap, correct for non-power-of-2 N.
  - No advance on a non-accepted cycle, whether or not the lane is idle.
- Waiting on a lane:
  - If lane sel has tvalid=0, the block waits indefinitely.
  - Other lanes' valid beats are held off through tready=0. No reordering, no timeout.
- Single-beat packets (tvalid=1, tlast=1 on the first beat) advance the pointer after that one beat.
- Downstream stall during a lane switch:
  - The beat in the output register stays.
  - The new lane is not accepted until out_free=1.
- tlast is passed through unmodified. The block never generates or suppresses tlast.
- Protocol violation: upstream dropping tvalid mid-packet is legal. The block simply waits on the same lane.

Test Plan:
1. Reset, N=2, PACKET_MODE=1, axis_o_tready=1. Lane0 sends 3-beat packet A0..A2 and lane1 sends 2-beat packet B0..B1, both valid from cycle 0.
   -> Output A0,A1,A2(last),B0,B1(last) on consecutive cycles starting 1 cycle after the first accept. axis_i_tready[1]=0 until A2 is accepted.
2. N=3, PACKET_MODE=1. Lane1 valid first with 1-beat packet 0x11, lane0 valid 5 cycles later with 0x00, lane2 with 0x22.
   -> Output order 0x00, 0x11, 0x22. Lane1 is held with tready=0 for 5+ cycles. sel wraps to 0 after 0x22.
3. PACKET_MODE=0, N=2. Both lanes stream beats 0x10..0x13 and 0x20..0x23 with tlast=0.
   -> Output interleaves 0x10,0x20,0x11,0x21,… at 1 beat/cycle.
4. Backpressure: axis_o_tready toggles 1,0,0,1 during the test-1 traffic.
   -> No beat lost or duplicated. axis_o_tdata/tlast stable while tvalid=1 and tready=0. Order unchanged.
5. Reset mid-packet: assert sresetn=0 after A1 is accepted, release, then lane0 sends C0(last).
   -> axis_o_tvalid=0 the cycle after reset. tready all 0 during reset. C0 output next with sel back at 0.
6. N=3 (non-power-of-2), 9 single-beat packets fed in rotation.
   -> sel sequence 0,1,2,0,1,2,0,1,2. sel never reaches 3.

Source files
------------

// File: rtl/axis_round_robin_merge.sv
// axis_round_robin_merge: recombines N AXI-Stream lanes in strict rotating lane order
// behind a single registered output stage.
module axis_round_robin_merge #(
    parameter int AXIS_BYTES         = 1,
    parameter int NUM_MASTER_STREAMS = 2,
    parameter int PACKET_MODE        = 1
) (
    input  logic                                           clk,
    input  logic                                           sresetn,
    output logic [NUM_MASTER_STREAMS-1:0]                  axis_i_tready,
    input  logic [NUM_MASTER_STREAMS-1:0]                  axis_i_tvalid,
    input  logic [NUM_MASTER_STREAMS*AXIS_BYTES*8-1:0]     axis_i_tdata,
    input  logic [NUM_MASTER_STREAMS-1:0]                  axis_i_tlast,
    input  logic                                           axis_o_tready,
    output logic                                           axis_o_tvalid,
    output logic [AXIS_BYTES*8-1:0]                        axis_o_tdata,
    output logic                                           axis_o_tlast
);
    localparam int W  = AXIS_BYTES * 8;
    localparam int N  = NUM_MASTER_STREAMS;
    localparam int SW = (N > 2) ? $clog2(N) : 1;
    localparam logic [SW-1:0] SEL_MAX = SW'(N - 1);

    logic [SW-1:0] sel_q, sel_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  lane_data;
    logic          lane_valid, lane_last, out_free, accept;

    assign out_free      = !valid_q | axis_o_tready;
    assign lane_valid    = axis_i_tvalid[sel_q];
    assign lane_last     = axis_i_tlast[sel_q];
    assign lane_data     = axis_i_tdata[sel_q*W +: W];
    assign axis_i_tready = (sresetn & out_free) ? N'(1) << sel_q : '0;
    assign accept        = lane_valid & sresetn & out_free;

    // Explicit wrap keeps the pointer inside 0..N-1 for non-power-of-2 N.
    always_comb begin
        valid_d = out_free ? accept : valid_q;
        data_d  = accept ? lane_data : data_q;
        last_d  = accept ? lane_last : last_q;
        sel_d   = (accept && (PACKET_MODE == 0 || lane_last)) ?
                  ((sel_q == SEL_MAX) ? '0 : sel_q + SW'(1)) : sel_q;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            sel_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign axis_o_tvalid = valid_q;
    assign axis_o_tdata  = data_q;
    assign axis_o_tlast  = last_q;
endmodule

// File: tb/tb_axis_round_robin_merge.sv
// tb_axis_round_robin_merge: directed checks of lane ordering, backpressure, reset and
// wrap-around for N=2/N=3 packet mode and N=2 beat mode.
module tb_axis_round_robin_merge;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]  v2, tr2, l2;
    logic [15:0] d2;
    logic        otr2, ov2, ol2;
    logic [7:0]  od2;

    logic [2:0]  v3, tr3, l3;
    logic [23:0] d3;
    logic        ov3, ol3;
    logic [7:0]  od3;

    logic [1:0]  v0, tr0, l0;
    logic [15:0] d0;
    logic        ov0, ol0;
    logic [7:0]  od0;

    axis_round_robin_merge #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(2), .PACKET_MODE(1)) u2 (
        .clk(clk), .sresetn(rstn), .axis_i_tready(tr2), .axis_i_tvalid(v2), .axis_i_tdata(d2),
        .axis_i_tlast(l2), .axis_o_tready(otr2), .axis_o_tvalid(ov2), .axis_o_tdata(od2),
        .axis_o_tlast(ol2));
    axis_round_robin_merge #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(3), .PACKET_MODE(1)) u3 (
        .clk(clk), .sresetn(rstn), .axis_i_tready(tr3), .axis_i_tvalid(v3), .axis_i_tdata(d3),
        .axis_i_tlast(l3), .axis_o_tready(1'b1), .axis_o_tvalid(ov3), .axis_o_tdata(od3),
        .axis_o_tlast(ol3));
    axis_round_robin_merge #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(2), .PACKET_MODE(0)) u0 (
        .clk(clk), .sresetn(rstn), .axis_i_tready(tr0), .axis_i_tvalid(v0), .axis_i_tdata(d0),
        .axis_i_tlast(l0), .axis_o_tready(1'b1), .axis_o_tvalid(ov0), .axis_o_tdata(od0),
        .axis_o_tlast(ol0));

    typedef struct {
        logic       rstn;
        logic [1:0] v;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] l;
        logic       otr;
        logic [1:0] etr;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       cd;
    } vec_t;

    vec_t tbl [24];
    int errors = 0;
    int checks = 0;

    logic [7:0] q3 [3][3];
    int n3 [3];
    int st3 [3];
    int ix [3];
    logic [7:0] e3 [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run3(input string nm, input int ne, input bit hold);
        int got = 0;
        int first = -1;
        int lastc = -1;
        logic [2:0] hs;
        ix = '{0, 0, 0};
        for (int c = 0; c < 40 && got < ne; c++) begin
            for (int k = 0; k < 3; k++) begin
                v3[k] = (ix[k] < n3[k]) && (c >= st3[k]);
                d3[k*8 +: 8] = q3[k][(ix[k] < 3) ? ix[k] : 0];
            end
            l3 = 3'b111;
            #3;
            hs = v3 & tr3;
            if (hold && c <= 5) chk({nm, "_lane1_held"}, {31'd0, tr3[1]}, 32'd0);
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) if (hs[k]) ix[k]++;
            if (ov3) begin
                chk({nm, "_data"}, {24'd0, od3}, {24'd0, e3[got]});
                chk({nm, "_last"}, {31'd0, ol3}, 32'd1);
                got++;
                if (first < 0) first = c;
                lastc = c;
            end
        end
        v3 = '0;
        chk({nm, "_count"}, got, ne);
        chk({nm, "_span"}, lastc - first + 1, ne);
    endtask

    initial begin
        //            rst  v      a      b      l      otr   etr    ev    ed     el    cd
        tbl[0]  = '{1'b0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 2'b11, 8'hA0, 8'hB0, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 2'b11, 8'hA0, 8'hB0, 2'b00, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'b11, 8'hA1, 8'hB0, 2'b00, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 2'b11, 8'hA2, 8'hB0, 2'b01, 1'b1, 2'b01, 1'b1, 8'hA2, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 2'b10, 8'hA2, 8'hB0, 2'b00, 1'b1, 2'b10, 1'b1, 8'hB0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'b10, 8'hA2, 8'hB1, 2'b10, 1'b1, 2'b10, 1'b1, 8'hB1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 8'hA0, 8'hB0, 2'b00, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'b11, 8'hA1, 8'hB0, 2'b00, 1'b0, 2'b00, 1'b1, 8'hA0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 2'b11, 8'hA1, 8'hB0, 2'b00, 1'b0, 2'b00, 1'b1, 8'hA0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 2'b11, 8'hA1, 8'hB0, 2'b00, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 2'b11, 8'hA2, 8'hB0, 2'b01, 1'b1, 2'b01, 1'b1, 8'hA2, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 2'b10, 8'hA2, 8'hB0, 2'b00, 1'b0, 2'b00, 1'b1, 8'hA2, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 2'b10, 8'hA2, 8'hB0, 2'b00, 1'b0, 2'b00, 1'b1, 8'hA2, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 2'b10, 8'hA2, 8'hB0, 2'b00, 1'b1, 2'b10, 1'b1, 8'hB0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 2'b10, 8'hA2, 8'hB1, 2'b10, 1'b1, 2'b10, 1'b1, 8'hB1, 1'b1, 1'b1};
        tbl[17] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 2'b01, 8'hA0, 8'h00, 2'b00, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 2'b01, 8'hA1, 8'h00, 2'b00, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 2'b01, 8'hA2, 8'h00, 2'b01, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[21] = '{1'b1, 2'b11, 8'hC0, 8'hB5, 2'b01, 1'b1, 2'b01, 1'b1, 8'hC0, 1'b1, 1'b1};
        tbl[22] = '{1'b1, 2'b10, 8'hC0, 8'hB5, 2'b10, 1'b1, 2'b10, 1'b1, 8'hB5, 1'b1, 1'b1};
        tbl[23] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};

        v3 = '0; d3 = '0; l3 = '0;
        v0 = '0; d0 = '0; l0 = '0;
        for (int i = 0; i < 24; i++) begin
            rstn = tbl[i].rstn;
            v2   = tbl[i].v;
            d2   = {tbl[i].b, tbl[i].a};
            l2   = tbl[i].l;
            otr2 = tbl[i].otr;
            #3;
            chk($sformatf("vec%0d_tready", i), {30'd0, tr2}, {30'd0, tbl[i].etr});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_tvalid", i), {31'd0, ov2}, {31'd0, tbl[i].ev});
            if (tbl[i].cd) begin
                chk($sformatf("vec%0d_tdata", i), {24'd0, od2}, {24'd0, tbl[i].ed});
                chk($sformatf("vec%0d_tlast", i), {31'd0, ol2}, {31'd0, tbl[i].el});
            end
        end
        v2 = '0;
        rstn = 1'b1;

        q3[0][0] = 8'h00; q3[1][0] = 8'h11; q3[2][0] = 8'h22;
        n3 = '{1, 1, 1};
        st3 = '{5, 0, 0};
        e3[0] = 8'h00; e3[1] = 8'h11; e3[2] = 8'h22;
        run3("n3_order", 3, 1'b1);

        for (int k = 0; k < 3; k++) for (int j = 0; j < 3; j++) q3[k][j] = 8'(8'h30 + 3*j + k);
        for (int i = 0; i < 9; i++) e3[i] = 8'(8'h30 + i);
        n3 = '{3, 3, 3};
        st3 = '{0, 0, 0};
        run3("n3_wrap", 9, 1'b0);

        begin
            int a = 0;
            int b = 0;
            int got = 0;
            int first = -1;
            int lastc = -1;
            logic [1:0] hs;
            logic [7:0] exp;
            for (int c = 0; c < 30 && got < 8; c++) begin
                v0 = {b < 4, a < 4};
                d0 = {8'(8'h20 + b), 8'(8'h10 + a)};
                l0 = 2'b00;
                #3;
                hs = v0 & tr0;
                @(posedge clk);
                #1;
                if (hs[0]) a++;
                if (hs[1]) b++;
                if (ov0) begin
                    exp = (got % 2 == 0) ? 8'(8'h10 + got/2) : 8'(8'h20 + got/2);
                    chk("beat_mode_data", {24'd0, od0}, {24'd0, exp});
                    chk("beat_mode_last", {31'd0, ol0}, 32'd0);
                    got++;
                    if (first < 0) first = c;
                    lastc = c;
                end
            end
            v0 = '0;
            chk("beat_mode_count", got, 8);
            chk("beat_mode_span", lastc - first + 1, 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
